// File: rtl/encode_n_pipe_pkg.sv
// Shared definitions for the registered N-to-log2(N) encoder.
// Mode encodings are fixed by the downstream select/arbitration logic.
package encode_pkg;

   typedef enum logic [1:0] {
      MODE_ONEHOT = 2'b00,
      MODE_LSB    = 2'b01,
      MODE_RR     = 2'b10,
      MODE_MSB    = 2'b11
   } mode_e;

endpackage

// File: rtl/encode_n_pipe_if.sv
// Request/result bundle for encode_n_pipe: captured request on one side,
// registered encoded result plus error status on the other.
interface encode_n_pipe_if #(
   parameter int N         = 8,
   parameter int W         = $clog2(N),
   parameter int ERR_CNT_W = 8
);
   logic                 ena;
   logic [N-1:0]         in;
   logic [1:0]           mode;
   logic                 out_ready;
   logic                 err_clr;
   logic                 out_valid;
   logic [W-1:0]         sel;
   logic                 err;
   logic                 multi;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport master (
      output ena, in, mode, out_ready, err_clr,
      input  out_valid, sel, err, multi, err_cnt
   );

   modport slave (
      input  ena, in, mode, out_ready, err_clr,
      output out_valid, sel, err, multi, err_cnt
   );
endinterface

// File: rtl/encode_n_pipe_prio_enc_lsb.sv
// Combinational lowest-set-bit priority encoder; found=0 means vec is zero
// and idx is then 0.
module prio_enc_lsb #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         found
);

   always_comb begin
      idx   = '0;
      found = |vec;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = W'(i);
         end
      end
   end

endmodule

// File: rtl/encode_n_pipe.sv
// Registered N-to-log2(N) encoder: one-hot / LSB / MSB / round-robin modes
// behind a valid/ready output register, with a saturating error counter.
module encode_n_pipe
   import encode_pkg::*;
#(
   parameter int N         = 8,
   parameter int W         = $clog2(N),
   parameter int ERR_CNT_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   encode_n_pipe_if.slave  bus
);

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      return (&c) ? c : c + ERR_CNT_W'(1);
   endfunction

   // Wrap explicitly at N-1 so non-power-of-two N never points past the top line.
   function automatic logic [W-1:0] next_ptr(input logic [W-1:0] s);
      return (s == W'(N - 1)) ? '0 : s + W'(1);
   endfunction

   logic [N-1:0]         in_rev;
   logic [N-1:0]         in_mask;
   logic [W-1:0]         idx_lsb, idx_rev, idx_mask;
   logic                 fnd_lsb, fnd_rev, fnd_mask;
   logic [W-1:0]         rr_ptr;

   logic                 multi_p0;
   logic                 err_p0;
   logic [W-1:0]         sel_p0;
   logic                 acc_p0;

   logic                 vld_p1;
   logic [W-1:0]         sel_p1;
   logic                 err_p1;
   logic                 multi_p1;
   logic [ERR_CNT_W-1:0] err_cnt;

   // ---- stage p0: combinational encode of the presented request ----
   always_comb begin
      in_rev  = '0;
      in_mask = '0;
      for (int i = 0; i < N; i++) begin
         in_rev[i]  = bus.in[N - 1 - i];
         in_mask[i] = bus.in[i] && (i >= int'(rr_ptr));
      end
   end

   prio_enc_lsb #(.N(N), .W(W)) u_enc_lsb (
      .vec   (bus.in),
      .idx   (idx_lsb),
      .found (fnd_lsb)
   );

   prio_enc_lsb #(.N(N), .W(W)) u_enc_rev (
      .vec   (in_rev),
      .idx   (idx_rev),
      .found (fnd_rev)
   );

   prio_enc_lsb #(.N(N), .W(W)) u_enc_mask (
      .vec   (in_mask),
      .idx   (idx_mask),
      .found (fnd_mask)
   );

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_p0 = |(bus.in & (bus.in - N'(1)));

   always_comb begin
      sel_p0 = '0;
      err_p0 = 1'b1;
      case (mode_e'(bus.mode))
         MODE_ONEHOT: begin
            if (fnd_lsb && !multi_p0) begin
               sel_p0 = idx_lsb;
               err_p0 = 1'b0;
            end
         end
         MODE_LSB: begin
            if (fnd_lsb) begin
               sel_p0 = idx_lsb;
               err_p0 = 1'b0;
            end
         end
         MODE_MSB: begin
            if (fnd_rev) begin
               sel_p0 = W'(N - 1) - idx_rev;
               err_p0 = 1'b0;
            end
         end
         MODE_RR: begin
            // Nothing at or above rr_ptr: wrap around to the unmasked lowest bit.
            if (fnd_mask) begin
               sel_p0 = idx_mask;
               err_p0 = 1'b0;
            end else if (fnd_lsb) begin
               sel_p0 = idx_lsb;
               err_p0 = 1'b0;
            end
         end
         default: begin
            sel_p0 = '0;
            err_p0 = 1'b1;
         end
      endcase
   end

   assign acc_p0 = bus.ena && (!vld_p1 || bus.out_ready);

   // ---- stage p1: output register and handshake ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         sel_p1   <= '0;
         err_p1   <= 1'b0;
         multi_p1 <= 1'b0;
      end else if (acc_p0) begin
         vld_p1   <= 1'b1;
         sel_p1   <= sel_p0;
         err_p1   <= err_p0;
         multi_p1 <= multi_p0;
      end else if (bus.out_ready) begin
         vld_p1   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (acc_p0 && (bus.mode == MODE_RR) && !err_p0) begin
         rr_ptr <= next_ptr(sel_p0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (bus.err_clr) begin
         err_cnt <= '0;
      end else if (acc_p0 && err_p0) begin
         err_cnt <= sat_inc(err_cnt);
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.sel       = sel_p1;
   assign bus.err       = err_p1;
   assign bus.multi     = multi_p1;
   assign bus.err_cnt   = err_cnt;

endmodule

// File: tb/tb_encode_n_pipe.sv
// Bench for encode_n_pipe: an N=8 instance and an N=5 / 2-bit-counter instance,
// directed tables plus randomized traffic against a behavioural model.
module tb_encode_n_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   encode_n_pipe_if #(.N(8), .ERR_CNT_W(8)) a_if ();
   encode_n_pipe_if #(.N(5), .ERR_CNT_W(2)) b_if ();

   encode_n_pipe #(.N(8), .ERR_CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
   encode_n_pipe #(.N(5), .ERR_CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic       ena;
      logic [7:0] in;
      logic [1:0] mode;
      logic       rdy;
      logic       clr;
      logic       vld;
      int         sel;
      logic       err;
      logic       multi;
      int         cnt;
   } vec_t;
   vec_t tbl[$];

   // Behavioural model state, index 0 = N8 instance, 1 = N5 instance
   bit   m_valid[2];
   int   m_sel[2];
   logic m_err[2];
   logic m_multi[2];
   int   m_cnt[2];
   int   m_ptr[2];
   int   nn[2]   = '{8, 5};
   int   cmax[2] = '{255, 3};

   task automatic chk(input string nm, input int idx, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
      end
   endtask

   function automatic void ref_enc(input logic [7:0] v, input int n, input logic [1:0] md,
                                   input int ptr, output int s, output logic e);
      logic [7:0] vm;
      int ones;
      vm   = v & 8'((1 << n) - 1);
      ones = $countones(vm);
      s = 0;
      e = 1'b1;
      case (md)
         2'b00: if (ones == 1) begin
            e = 1'b0;
            for (int i = 0; i < n; i++) if (vm[i]) s = i;
         end
         2'b01: if (ones > 0) begin
            e = 1'b0;
            for (int i = n - 1; i >= 0; i--) if (vm[i]) s = i;
         end
         2'b11: if (ones > 0) begin
            e = 1'b0;
            for (int i = 0; i < n; i++) if (vm[i]) s = i;
         end
         default: if (ones > 0) begin
            e = 1'b0;
            for (int k = n - 1; k >= 0; k--) if (vm[(ptr + k) % n]) s = (ptr + k) % n;
         end
      endcase
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_valid[d] = 0; m_sel[d] = 0; m_err[d] = 0; m_multi[d] = 0;
         m_cnt[d] = 0;   m_ptr[d] = 0;
      end
   endtask

   // Advance the model on the inputs currently presented, then step one clock.
   task automatic tick();
      for (int d = 0; d < 2; d++) begin
         logic e, r, c, er;
         logic [7:0] v;
         logic [1:0] md;
         bit acc;
         int s;
         if (d == 0) begin
            e = a_if.ena; v = a_if.in; md = a_if.mode; r = a_if.out_ready; c = a_if.err_clr;
         end else begin
            e = b_if.ena; v = {3'b000, b_if.in}; md = b_if.mode; r = b_if.out_ready; c = b_if.err_clr;
         end
         acc = e && (!m_valid[d] || r);
         er = 1'b0;
         if (acc) begin
            ref_enc(v, nn[d], md, m_ptr[d], s, er);
            m_valid[d] = 1;
            m_sel[d]   = s;
            m_err[d]   = er;
            m_multi[d] = ($countones(v) > 1);
            if (md == 2'b10 && !er) m_ptr[d] = (s + 1) % nn[d];
         end else if (r) begin
            m_valid[d] = 0;
         end
         if (c) m_cnt[d] = 0;
         else if (acc && er && m_cnt[d] < cmax[d]) m_cnt[d]++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input int d, input int idx);
      if (d == 0) begin
         chk("a.vld", idx, int'(a_if.out_valid), int'(m_valid[0]));
         chk("a.sel", idx, int'(a_if.sel), m_sel[0]);
         chk("a.err", idx, int'(a_if.err), int'(m_err[0]));
         chk("a.multi", idx, int'(a_if.multi), int'(m_multi[0]));
         chk("a.cnt", idx, int'(a_if.err_cnt), m_cnt[0]);
      end else begin
         chk("b.vld", idx, int'(b_if.out_valid), int'(m_valid[1]));
         chk("b.sel", idx, int'(b_if.sel), m_sel[1]);
         chk("b.err", idx, int'(b_if.err), int'(m_err[1]));
         chk("b.multi", idx, int'(b_if.multi), int'(m_multi[1]));
         chk("b.cnt", idx, int'(b_if.err_cnt), m_cnt[1]);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".a.vld"}, 0, int'(a_if.out_valid), 0);
      chk({tag, ".a.sel"}, 0, int'(a_if.sel), 0);
      chk({tag, ".a.err"}, 0, int'(a_if.err), 0);
      chk({tag, ".a.multi"}, 0, int'(a_if.multi), 0);
      chk({tag, ".a.cnt"}, 0, int'(a_if.err_cnt), 0);
      chk({tag, ".b.vld"}, 0, int'(b_if.out_valid), 0);
      chk({tag, ".b.sel"}, 0, int'(b_if.sel), 0);
      chk({tag, ".b.cnt"}, 0, int'(b_if.err_cnt), 0);
   endtask

   task automatic addv(input logic ena, input logic [7:0] in, input logic [1:0] mode,
                       input logic rdy, input logic clr, input logic vld, input int sel,
                       input logic err, input logic multi, input int cnt);
      vec_t t;
      t = '{ena, in, mode, rdy, clr, vld, sel, err, multi, cnt};
      tbl.push_back(t);
   endtask

   task automatic drive_b(input logic ena, input logic [4:0] in, input logic [1:0] mode,
                          input logic rdy, input logic clr);
      b_if.ena = ena; b_if.in = in; b_if.mode = mode; b_if.out_ready = rdy; b_if.err_clr = clr;
   endtask

   function automatic logic [7:0] rnd_in(input int n);
      logic [7:0] v;
      case ($urandom % 4)
         0: v = 8'h00;
         1: v = 8'(1 << ($urandom % n));
         2: v = 8'((1 << ($urandom % n)) | (1 << ($urandom % n)));
         default: v = 8'($urandom);
      endcase
      return v & 8'((1 << n) - 1);
   endfunction

   initial begin
      int sb[6];
      rst_n = 1'b0;
      a_if.ena = 0; a_if.in = 8'h01; a_if.mode = 0; a_if.out_ready = 1; a_if.err_clr = 0;
      drive_b(0, 5'h00, 2'b00, 1, 0);
      model_reset();
      #12;
      chk_zero("reset");
      rst_n = 1'b1;

      // ena,in,mode,rdy,clr -> vld,sel,err,multi,cnt  (as seen after the edge)
      addv(0, 8'h01, 2'b00, 1, 0, 0, 0, 0, 0, 0);
      addv(1, 8'h01, 2'b00, 1, 0, 1, 0, 0, 0, 0);
      addv(1, 8'h04, 2'b00, 1, 0, 1, 2, 0, 0, 0);
      addv(1, 8'h80, 2'b00, 1, 0, 1, 7, 0, 0, 0);
      addv(1, 8'h03, 2'b00, 1, 0, 1, 0, 1, 1, 1);
      addv(1, 8'hFF, 2'b00, 1, 0, 1, 0, 1, 1, 2);
      addv(1, 8'h00, 2'b00, 1, 0, 1, 0, 1, 0, 3);
      addv(1, 8'h68, 2'b01, 1, 0, 1, 3, 0, 1, 3);
      addv(1, 8'h68, 2'b11, 1, 0, 1, 6, 0, 1, 3);
      addv(1, 8'h00, 2'b01, 1, 0, 1, 0, 1, 0, 4);
      addv(1, 8'h00, 2'b11, 1, 0, 1, 0, 1, 0, 5);
      for (int k = 0; k < 10; k++) addv(1, 8'hFF, 2'b10, 1, 0, 1, k % 8, 0, 1, 5);
      addv(1, 8'h81, 2'b10, 1, 0, 1, 7, 0, 1, 5);
      addv(1, 8'h81, 2'b10, 1, 0, 1, 0, 0, 1, 5);
      addv(1, 8'h04, 2'b00, 1, 0, 1, 2, 0, 0, 5);
      addv(1, 8'h00, 2'b00, 0, 0, 1, 2, 0, 0, 5);
      addv(1, 8'h03, 2'b00, 0, 0, 1, 2, 0, 0, 5);
      addv(1, 8'h10, 2'b00, 1, 0, 1, 4, 0, 0, 5);
      addv(0, 8'h00, 2'b00, 1, 0, 0, 4, 0, 0, 5);
      addv(0, 8'h00, 2'b00, 0, 0, 0, 4, 0, 0, 5);
      addv(1, 8'h00, 2'b01, 1, 1, 1, 0, 1, 0, 0);
      addv(1, 8'h00, 2'b01, 1, 0, 1, 0, 1, 0, 1);
      addv(0, 8'h00, 2'b01, 1, 1, 0, 0, 1, 0, 0);

      foreach (tbl[i]) begin
         a_if.ena = tbl[i].ena; a_if.in = tbl[i].in; a_if.mode = tbl[i].mode;
         a_if.out_ready = tbl[i].rdy; a_if.err_clr = tbl[i].clr;
         tick();
         chk("tbl.vld", i, int'(a_if.out_valid), int'(tbl[i].vld));
         chk("tbl.sel", i, int'(a_if.sel), tbl[i].sel);
         chk("tbl.err", i, int'(a_if.err), int'(tbl[i].err));
         chk("tbl.multi", i, int'(a_if.multi), int'(tbl[i].multi));
         chk("tbl.cnt", i, int'(a_if.err_cnt), tbl[i].cnt);
      end
      a_if.ena = 0; a_if.err_clr = 0;

      // N=5 round-robin wrap from 4 back to 0, then a sparse request
      sb = '{0, 1, 2, 3, 4, 0};
      for (int k = 0; k < 6; k++) begin
         drive_b(1, 5'h1F, 2'b10, 1, 0);
         tick();
         chk("b.rr", k, int'(b_if.sel), sb[k]);
      end
      drive_b(1, 5'b10001, 2'b10, 1, 0);
      tick();
      chk("b.rr_sparse", 0, int'(b_if.sel), 4);
      tick();
      chk("b.rr_sparse", 1, int'(b_if.sel), 0);

      // 2-bit counter saturates at 3; clear beats a concurrent increment
      sb = '{1, 2, 3, 3, 3, 0};
      for (int k = 0; k < 5; k++) begin
         drive_b(1, 5'h00, 2'b01, 1, 0);
         tick();
         chk("b.sat", k, int'(b_if.err_cnt), sb[k]);
         chk("b.sat_err", k, int'(b_if.err), 1);
      end
      drive_b(1, 5'h00, 2'b01, 1, 1);
      tick();
      chk("b.clr_wins", 0, int'(b_if.err_cnt), 0);
      drive_b(0, 5'h00, 2'b00, 1, 0);
      tick();

      // Randomized traffic on both instances against the model
      for (int c = 0; c < 400; c++) begin
         a_if.ena = ($urandom % 4) != 0;
         a_if.in = rnd_in(8);
         a_if.mode = 2'($urandom);
         a_if.out_ready = ($urandom % 4) != 0;
         a_if.err_clr = ($urandom % 32) == 0;
         drive_b(($urandom % 4) != 0, 5'(rnd_in(5)), 2'($urandom),
                 ($urandom % 4) != 0, ($urandom % 32) == 0);
         tick();
         chk_model(0, c);
         chk_model(1, c);
      end

      // Asynchronous reset in mid-stream, between clock edges
      a_if.ena = 1; a_if.in = 8'h00; a_if.mode = 2'b01; a_if.out_ready = 1; a_if.err_clr = 0;
      drive_b(1, 5'h00, 2'b01, 1, 0);
      tick();
      a_if.in = 8'hFF; a_if.mode = 2'b10;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      chk_zero("rst_held");
      #3 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk_model(0, 1000 + c);
         chk_model(1, 1000 + c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
